// File: rtl/oled_frame_sequencer_pkg.sv
// Shared definitions for the OLED frame sequencer: FSM encoding, frame geometry, blank code.
// The index is fixed at 6 bits (4 pages x 16 columns); NUM_CHARS must not exceed 64.
`timescale 1ns/1ps
package oled_frame_sequencer_pkg;

  localparam int CHAR_W = 8;
  localparam int IDX_W = 6;
  localparam int DEF_NUM_CHARS = 64;
  localparam logic [CHAR_W-1:0] DEF_BLANK_CHAR = 8'h20;

  typedef logic [CHAR_W-1:0] char_t;
  typedef logic [IDX_W-1:0] charIdx_t;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_FETCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_RELEASE = 3'd4
  } seqState_t;

  function automatic logic isLastIdx(input charIdx_t i, input int numChars);
    return i == IDX_W'(numChars - 1);
  endfunction

endpackage

// File: rtl/oled_frame_sequencer_screen_buffer.sv
// 64x8 character screen buffer: one synchronous write port, one registered read port (1-cycle latency).
// A read and write to the same address in one cycle return the old contents; no reset on the array.
`timescale 1ns/1ps
module screen_buffer #(
  parameter int DEPTH = 64,
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [DW-1:0] wrData,
  input  logic          rdEn,
  input  logic [AW-1:0] rdAddr,
  output logic [DW-1:0] rdData
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
    if (rdEn) begin
      rdData <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/oled_frame_sequencer.sv
// Streams the 64-char screen buffer to the OLED controller one char per sendDone handshake.
// Valid rises 2 cycles after a fetch starts and is held until acknowledged; requests arriving while busy are queued as pending flags.
`timescale 1ns/1ps
module oled_frame_sequencer
  import oled_frame_sequencer_pkg::*;
#(
  parameter int    NUM_CHARS  = DEF_NUM_CHARS,
  parameter char_t BLANK_CHAR = DEF_BLANK_CHAR
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [7:0]       wr_char,
  input  logic             refresh_req,
  input  logic             clear_req,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       send_data,
  output logic             send_data_valid,
  input  logic             send_done
);

  seqState_t state;
  charIdx_t  idx;
  logic      fetchPhase;
  logic      refreshPend;
  logic      clearPend;
  logic      atLast;
  logic      streaming;

  logic     bufWrEn;
  charIdx_t bufWrAddr;
  char_t    bufWrData;
  logic     bufRdEn;
  char_t    bufRdData;

  assign atLast    = isLastIdx(idx, NUM_CHARS);
  assign streaming = (state == ST_FETCH) || (state == ST_SEND) || (state == ST_RELEASE);

  // CLEAR owns the write port; user writes are dropped while it runs.
  always_comb begin
    bufWrEn   = wr_en;
    bufWrAddr = wr_addr;
    bufWrData = wr_char;
    if (state == ST_CLEAR) begin
      bufWrEn   = 1'b1;
      bufWrAddr = idx;
      bufWrData = BLANK_CHAR;
    end
  end

  assign bufRdEn = (state == ST_FETCH) && !fetchPhase;

  screen_buffer #(
    .DEPTH(NUM_CHARS),
    .AW   (IDX_W),
    .DW   (CHAR_W)
  ) uBuffer (
    .clock (clock),
    .wrEn  (bufWrEn),
    .wrAddr(bufWrAddr),
    .wrData(bufWrData),
    .rdEn  (bufRdEn),
    .rdAddr(idx),
    .rdData(bufRdData)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_CLEAR;
      idx             <= '0;
      fetchPhase      <= 1'b0;
      busy            <= 1'b1;
      frame_done      <= 1'b0;
      send_data       <= 8'h00;
      send_data_valid <= 1'b0;
      refreshPend     <= 1'b0;
      clearPend       <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (streaming) begin
        if (refresh_req) refreshPend <= 1'b1;
        if (clear_req)   clearPend   <= 1'b1;
      end

      case (state)
        ST_CLEAR: begin
          if (refresh_req) refreshPend <= 1'b1;
          if (atLast) begin
            idx   <= '0;
            state <= ST_IDLE;
            busy  <= refreshPend | refresh_req;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        ST_IDLE: begin
          if (clear_req || clearPend) begin
            state       <= ST_CLEAR;
            idx         <= '0;
            busy        <= 1'b1;
            clearPend   <= 1'b0;
            refreshPend <= refreshPend | refresh_req;
          end else if (refresh_req || refreshPend) begin
            state       <= ST_FETCH;
            idx         <= '0;
            fetchPhase  <= 1'b0;
            busy        <= 1'b1;
            refreshPend <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end

        // Phase 0 issues the read, phase 1 registers the returned char onto the link.
        ST_FETCH: begin
          if (!fetchPhase) begin
            fetchPhase <= 1'b1;
          end else begin
            fetchPhase      <= 1'b0;
            send_data       <= bufRdData;
            send_data_valid <= 1'b1;
            state           <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (send_done) begin
            send_data_valid <= 1'b0;
            state           <= ST_RELEASE;
          end
        end

        // The controller holds sendDone for several cycles; wait for it to drop so each ack counts once.
        ST_RELEASE: begin
          if (!send_done) begin
            if (atLast) begin
              frame_done <= 1'b1;
              state      <= ST_IDLE;
              busy       <= refreshPend | clearPend | refresh_req | clear_req;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= ST_FETCH;
            end
          end
        end

        default: begin
          state <= ST_CLEAR;
          idx   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Scoreboard bench for oled_frame_sequencer with a variable-latency OLED controller model.
`timescale 1ns/1ps
module tb_oled_frame_sequencer;

  localparam int DONE_MARK = 256;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic       refresh_req = 1'b0;
  logic       clear_req = 1'b0;
  logic       busy;
  logic       frame_done;
  logic [7:0] send_data;
  logic       send_data_valid;
  logic       send_done = 1'b0;

  always #5 clock = ~clock;

  oled_frame_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_char        (wr_char),
    .refresh_req    (refresh_req),
    .clear_req      (clear_req),
    .busy           (busy),
    .frame_done     (frame_done),
    .send_data      (send_data),
    .send_data_valid(send_data_valid),
    .send_done      (send_done)
  );

  int         errors = 0;
  int         checks = 0;
  int         expQ[$];
  logic [7:0] frameExp [64];
  int         ackCount = 0;
  int         frameCount = 0;
  logic       busyAtDone = 1'b0;
  bit         ignoreAcks = 1'b0;
  int         latMax = 6;
  logic       monPrevValid = 1'b0;
  logic [7:0] monPrevData = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // OLED controller model: random ack latency, sendDone held high for several cycles.
  initial begin
    forever begin
      @(negedge clock);
      if (send_data_valid && reset_n) begin
        int lat;
        int hold;
        lat  = int'($urandom_range(latMax, 3));
        hold = int'($urandom_range(4, 2));
        repeat (lat) @(posedge clock);
        #1 send_done = 1'b1;
        repeat (hold) @(posedge clock);
        #1 send_done = 1'b0;
      end
    end
  end

  // Monitor: every accepted char and every frame_done pulse pops one expected entry.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (monPrevValid && send_data_valid)
          chk("send_data_stable", int'(send_data), int'(monPrevData));
        if (send_data_valid && send_done) begin
          ackCount++;
          if (!ignoreAcks) begin
            if (expQ.size() == 0) chk("unexpected_char", int'(send_data), -1);
            else chk($sformatf("char_ack%0d", ackCount), int'(send_data), expQ.pop_front());
          end
        end
        if (frame_done) begin
          frameCount++;
          busyAtDone = busy;
          if (!ignoreAcks) begin
            if (expQ.size() == 0) chk("unexpected_frame_done", DONE_MARK, -1);
            else chk("frame_done_position", DONE_MARK, expQ.pop_front());
          end
        end
      end
      monPrevValid = send_data_valid & reset_n;
      monPrevData  = send_data;
    end
  end

  task automatic pulseReq(input bit rf, input bit cl);
    @(posedge clock);
    #1 refresh_req = rf; clear_req = cl;
    @(posedge clock);
    #1 refresh_req = 1'b0; clear_req = 1'b0;
  endtask

  task automatic wrChar(input logic [5:0] a, input logic [7:0] c);
    @(posedge clock);
    #1 wr_en = 1'b1; wr_addr = a; wr_char = c;
    @(posedge clock);
    #1 wr_en = 1'b0;
  endtask

  task automatic fillFrame(input logic [7:0] c);
    for (int i = 0; i < 64; i++) frameExp[i] = c;
  endtask

  task automatic pushFrame();
    for (int i = 0; i < 64; i++) expQ.push_back(int'(frameExp[i]));
    expQ.push_back(DONE_MARK);
  endtask

  task automatic waitFrames(input int target, input string name);
    int cyc = 0;
    while (frameCount < target && cyc < 20000) begin
      @(negedge clock);
      cyc++;
    end
    chk({name, "_frame_reached"}, int'(frameCount >= target), 1);
  endtask

  task automatic waitAcks(input int target, input string name);
    int cyc = 0;
    while (ackCount < target && cyc < 5000) begin
      @(negedge clock);
      cyc++;
    end
    chk({name, "_ack_reached"}, int'(ackCount >= target), 1);
  endtask

  task automatic waitIdle(input string name);
    int cyc = 0;
    while (busy && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    chk({name, "_idle_reached"}, int'(busy), 0);
  endtask

  task automatic countBusy(output int n);
    n = 0;
    @(negedge clock);
    while (busy && n < 200) begin
      n++;
      @(negedge clock);
    end
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int baseAck;
    int cyc;

    // Reset state, then the 64-cycle CLEAR after release.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", int'(busy), 1);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_send_data", int'(send_data), 0);
    chk("rst_valid", int'(send_data_valid), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    countBusy(n);
    chk("reset_clear_cycles", n, 64);

    // Blank frame and request-to-valid timing.
    fillFrame(8'h20);
    pushFrame();
    base = frameCount;
    pulseReq(1'b1, 1'b0);
    @(negedge clock);
    chk("refresh_busy_rise", int'(busy), 1);
    chk("refresh_valid_c1", int'(send_data_valid), 0);
    @(negedge clock);
    chk("refresh_valid_c2", int'(send_data_valid), 0);
    @(negedge clock);
    chk("refresh_valid_c3", int'(send_data_valid), 1);
    waitFrames(base + 1, "blank");
    chk("blank_busy_at_done", int'(busyAtDone), 0);
    repeat (50) @(negedge clock);
    chk("blank_single_frame_done", frameCount, base + 1);

    // X at 0, O at 17 with long, variable ack latency.
    latMax = 40;
    wrChar(6'd0, 8'h58);
    wrChar(6'd17, 8'h4F);
    frameExp[0]  = 8'h58;
    frameExp[17] = 8'h4F;
    pushFrame();
    base = frameCount;
    baseAck = ackCount;
    pulseReq(1'b1, 1'b0);
    waitFrames(base + 1, "xo");
    chk("xo_ack_count", ackCount - baseAck, 64);
    latMax = 6;

    // Writes at idx 10: index 40 lands in this frame, index 5 only in the next.
    frameExp[40] = 8'h31;
    pushFrame();
    base = frameCount;
    baseAck = ackCount;
    pulseReq(1'b1, 1'b0);
    waitAcks(baseAck + 11, "midwrite");
    wrChar(6'd40, 8'h31);
    wrChar(6'd5, 8'h32);
    waitFrames(base + 1, "midwrite_f1");
    frameExp[5] = 8'h32;
    pushFrame();
    pulseReq(1'b1, 1'b0);
    waitFrames(base + 2, "midwrite_f2");

    // Three refreshes during a frame collapse into one more frame.
    pushFrame();
    pushFrame();
    base = frameCount;
    baseAck = ackCount;
    pulseReq(1'b1, 1'b0);
    waitAcks(baseAck + 5, "collapse");
    for (int k = 0; k < 3; k++) begin
      pulseReq(1'b1, 1'b0);
      repeat (2) @(posedge clock);
    end
    waitFrames(base + 1, "collapse_f1");
    chk("collapse_busy_held", int'(busyAtDone), 1);
    waitFrames(base + 2, "collapse_f2");
    chk("collapse_busy_dropped", int'(busyAtDone), 0);
    repeat (300) @(negedge clock);
    chk("collapse_frame_total", frameCount - base, 2);
    chk("collapse_queue_empty", expQ.size(), 0);

    // Clear at idx 30 leaves this frame intact; writes during CLEAR are dropped.
    pushFrame();
    base = frameCount;
    baseAck = ackCount;
    pulseReq(1'b1, 1'b0);
    waitAcks(baseAck + 31, "midclear");
    pulseReq(1'b0, 1'b1);
    waitFrames(base + 1, "midclear_f1");
    chk("midclear_busy_held", int'(busyAtDone), 1);
    repeat (10) @(negedge clock);
    wrChar(6'd0, 8'h41);
    waitIdle("midclear");
    fillFrame(8'h20);
    pushFrame();
    pulseReq(1'b1, 1'b0);
    waitFrames(base + 2, "midclear_f2");

    // Simultaneous clear and refresh in IDLE: clear first, then a blank frame.
    wrChar(6'd2, 8'h55);
    pushFrame();
    base = frameCount;
    pulseReq(1'b1, 1'b1);
    waitFrames(base + 1, "both");
    chk("both_busy_at_done", int'(busyAtDone), 0);
    chk("both_queue_empty", expQ.size(), 0);

    // Asynchronous reset while a char is presented.
    ignoreAcks = 1'b1;
    pulseReq(1'b1, 1'b0);
    cyc = 0;
    while (!send_data_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("arst_valid_seen", int'(send_data_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid_low", int'(send_data_valid), 0);
    chk("arst_busy", int'(busy), 1);
    chk("arst_send_data", int'(send_data), 0);
    chk("arst_frame_done", int'(frame_done), 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    countBusy(n);
    chk("arst_clear_cycles", n, 64);
    chk("arst_valid_after", int'(send_data_valid), 0);
    repeat (20) @(negedge clock);
    ignoreAcks = 1'b0;
    fillFrame(8'h20);
    pushFrame();
    base = frameCount;
    pulseReq(1'b1, 1'b0);
    waitFrames(base + 1, "after_arst");

    chk("final_queue_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
